axis_bram_streamer: RTL and testbench

AXIS_BRAM_STREAMER -- requirements
Module: axis_bram_streamer

---
 rtl/axis_bram_streamer.sv | 172 +++++++++++++++++
 tb/tb_axis_bram_streamer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_streamer.sv
// axis_bram_streamer: reads a burst of words from a BRAM through an external
// address counter and presents them on an AXI-Stream master port.
// Optional feature macro: AXIS_STREAMER_TLAST_EN (tlast generation from a beat
// counter); when undefined m_axis_tlast is tied low.
//
// state  | meaning
// IDLE   | waiting for start; zero-length bursts finish here
// LOAD   | one-cycle load of the address counter
// STREAM | issuing BRAM reads while the counter has addresses and credit exists
// DRAIN  | counter exhausted; waiting for in-flight read and FIFO to empty
module axis_bram_streamer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [15:0]       start_addr,
  input  logic [15:0]       count_limit,
  output logic              busy,
  output logic              done,
  output logic              cnt_start,
  output logic              cnt_enable,
  output logic [15:0]       cnt_start_addr,
  input  logic [15:0]       cnt_addr,
  input  logic              cnt_done,
  output logic              bram_en,
  output logic [15:0]       bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              inflight_q;
  logic [15:0]       addr_q;
  logic [1:0]        fifo_cnt_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] mem_q [2];

  logic              start_ok;
  logic              issue;
  logic              credit;
  logic              push;
  logic              pop;

  // Data arrives from the BRAM exactly one cycle after each issued read.
  assign push = inflight_q;
  assign pop  = m_axis_tvalid && m_axis_tready;

  // Occupancy counts the FIFO plus the read still in flight; a pop this cycle
  // frees a slot early so a full pipeline can sustain one beat per cycle.
  assign credit = ({1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;

  assign start_ok = start && !busy_q;

  // State register and burst control flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and combinational control outputs.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q && !done_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    cnt_start = 1'b0;
    bram_addr = 16'h0000;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          busy_d = 1'b1;
          if (count_limit != 16'h0000) state_d = LOAD;
          else                         done_d  = 1'b1;
        end
      end
      LOAD: begin
        cnt_start = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        issue     = !cnt_done && credit;
        bram_addr = cnt_addr;
        if (cnt_done) state_d = DRAIN;
      end
      DRAIN: begin
        // Finished once nothing is in flight and this pop (if any) empties the FIFO.
        if (!inflight_q && (fifo_cnt_q == {1'b0, pop})) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign cnt_enable     = issue;
  assign bram_en        = issue;
  assign cnt_start_addr = addr_q;

  // Latch the burst start address so later input changes cannot disturb the load.
  always_ff @(posedge aclk) begin
    if (!aresetn)      addr_q <= 16'h0000;
    else if (start_ok) addr_q <= start_addr;
  end

  // Track the read whose data lands on bram_dout next cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) inflight_q <= 1'b0;
    else          inflight_q <= issue;
  end

  // Two-entry FIFO; push and pop in the same cycle keep order and count intact.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      fifo_cnt_q <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bram_dout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;

`ifdef AXIS_STREAMER_TLAST_EN
  logic [15:0] beat_q;
  logic [15:0] limit_q;

  // Count accepted beats of the current burst against the latched length.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beat_q  <= 16'h0000;
      limit_q <= 16'h0000;
    end else if (start_ok) begin
      beat_q  <= 16'h0000;
      limit_q <= count_limit;
    end else if (pop) begin
      beat_q  <= beat_q + 16'd1;
    end
  end

  assign m_axis_tlast = m_axis_tvalid && (beat_q == limit_q - 16'd1);
`else
  assign m_axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_axis_bram_streamer.sv
// Self-checking bench for axis_bram_streamer: models the address counter and a
// one-cycle-latency BRAM, and scoreboards every stream beat against the
// expected word sequence queued when each burst is started.
module tb_axis_bram_streamer;

  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   start_addr = 16'h0000;
  logic [15:0]   count_limit = 16'h0000;
  logic          busy, done, cnt_start, cnt_enable;
  logic [15:0]   cnt_start_addr;
  logic [15:0]   cnt_addr;
  logic          cnt_done;
  logic          bram_en;
  logic [15:0]   bram_addr;
  logic [DW-1:0] bram_dout = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;

  axis_bram_streamer #(.DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .start_addr(start_addr),
    .count_limit(count_limit), .busy(busy), .done(done), .cnt_start(cnt_start),
    .cnt_enable(cnt_enable), .cnt_start_addr(cnt_start_addr), .cnt_addr(cnt_addr),
    .cnt_done(cnt_done), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Address counter model and BRAM model.
  logic [15:0] c_addr = 16'h0000;
  logic [15:0] c_issued = 16'h0000;
  logic [15:0] tb_limit = 16'h0000;
  assign cnt_addr = c_addr;
  assign cnt_done = (c_issued == tb_limit);

  always @(posedge aclk) begin
    if (!aresetn) begin
      c_addr   <= 16'h0000;
      c_issued <= 16'h0000;
    end else if (cnt_start) begin
      c_addr   <= cnt_start_addr;
      c_issued <= 16'h0000;
    end else if (cnt_enable) begin
      c_addr   <= c_addr + 16'd1;
      c_issued <= c_issued + 16'd1;
    end
  end

  always @(posedge aclk) begin
    if (bram_en) bram_dout <= data_of(bram_addr);
  end

  // tready driver: held high or toggled every cycle.
  bit toggle_mode = 1'b0;
  initial forever begin
    @(posedge aclk); #1;
    if (toggle_mode) m_axis_tready = ~m_axis_tready;
    else             m_axis_tready = 1'b1;
  end

  // Scoreboard and observation state.
  logic [DW:0] exp_q [$];
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, start_cyc = 0, load_cyc = 0;
  int first_valid_cyc = -1, first_pop_cyc = -1, last_pop_cyc = 0;
  int valid_cnt = 0, cnt_start_cnt = 0, beat_cnt = 0;
  int issued = 0, popped = 0;
  int done_base = 0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  initial forever begin
    @(negedge aclk);
    cyc++;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      automatic bit pop_now = m_axis_tvalid && m_axis_tready;
      automatic logic [DW:0] e;
      if (start && !busy) start_cyc = cyc;
      if (cnt_start) begin load_cyc = cyc; cnt_start_cnt++; end
      if (m_axis_tvalid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall) begin
        check_eq("stall_tdata", m_axis_tdata, prev_data);
        check_eq("stall_tlast", m_axis_tlast, prev_last);
      end
      if (bram_en) begin
        check_eq("credit", ((issued - popped - (pop_now ? 1 : 0)) < 2) ? 1 : 0, 1);
        issued++;
      end
      if (pop_now) begin
        popped++;
        beat_cnt++;
        last_pop_cyc = cyc;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", m_axis_tdata, 0);
          check_eq("extra_beat_present", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("tdata", m_axis_tdata, e[DW-1:0]);
          check_eq("tlast", m_axis_tlast, e[DW]);
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic start_burst(input logic [15:0] a, input logic [15:0] n);
    for (int i = 0; i < int'(n); i++) begin
      automatic logic [15:0] ai = a + 16'(i);
      automatic logic lst;
`ifdef AXIS_STREAMER_TLAST_EN
      lst = (i == int'(n) - 1);
`else
      lst = 1'b0;
`endif
      exp_q.push_back({lst, data_of(ai)});
    end
    tb_limit        = n;
    first_valid_cyc = -1;
    first_pop_cyc   = -1;
    beat_cnt        = 0;
    done_base       = done_cnt;
    start_addr      = a;
    count_limit     = n;
    start           = 1'b1;
    @(posedge aclk); #1;
    start       = 1'b0;
    start_addr  = 16'hDEAD;
    count_limit = 16'h0007;
  endtask

  task automatic wait_done(input string tag, input int n);
    int k = 0;
    while (done_cnt == done_base && k < 500) begin
      @(posedge aclk); #1;
      k++;
    end
    check_eq({tag, "_done_seen"}, (done_cnt != done_base) ? 1 : 0, 1);
    repeat (6) @(posedge aclk);
    #1;
    check_eq({tag, "_ndone"}, done_cnt - done_base, 1);
    check_eq({tag, "_beats"}, beat_cnt, n);
    check_eq({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_tvalid"}, m_axis_tvalid, 0);
    check_eq({tag, "_tlast"}, m_axis_tlast, 0);
    check_eq({tag, "_tdata"}, m_axis_tdata, 0);
    check_eq({tag, "_bram_en"}, bram_en, 0);
    check_eq({tag, "_bram_addr"}, bram_addr, 0);
    check_eq({tag, "_cnt_start"}, cnt_start, 0);
    check_eq({tag, "_cnt_enable"}, cnt_enable, 0);
  endtask

  initial begin
    int v0, c0, d0, k;

    // Reset values.
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("rst");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // Basic burst with latency and throughput checks.
    start_burst(16'd256, 16'd4);
    wait_done("b4", 4);
    check_eq("b4_first_valid_lat", first_valid_cyc - load_cyc, 3);
    check_eq("b4_consecutive", last_pop_cyc - first_pop_cyc, 3);
    check_eq("b4_done_lat", done_cyc - last_pop_cyc, 1);

    // Zero-length burst.
    v0 = valid_cnt;
    c0 = cnt_start_cnt;
    start_burst(16'h0040, 16'd0);
    wait_done("z0", 0);
    check_eq("z0_done_lat", done_cyc - start_cyc, 1);
    check_eq("z0_valid_cycles", valid_cnt - v0, 0);
    check_eq("z0_cnt_start", cnt_start_cnt - c0, 0);

    // Backpressure: tready toggling every cycle.
    toggle_mode = 1'b1;
    start_burst(16'h1000, 16'd8);
    wait_done("bp8", 8);
    toggle_mode = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Address wrap.
    start_burst(16'hFFFE, 16'd3);
    wait_done("wrap", 3);

    // Reset in the middle of a burst.
    start_burst(16'h0500, 16'd6);
    k = 0;
    while (beat_cnt < 2 && k < 200) begin
      @(posedge aclk); #1;
      k++;
    end
    check_eq("abort_two_beats", (beat_cnt >= 2) ? 1 : 0, 1);
    d0 = done_cnt;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("abort");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    exp_q.delete();
    issued = 0;
    popped = 0;
    repeat (8) @(posedge aclk);
    #1;
    check_eq("abort_no_done", done_cnt - d0, 0);
    check_eq("abort_no_valid", m_axis_tvalid, 0);
    start_burst(16'h0600, 16'd2);
    wait_done("post_abort", 2);

    // Start while busy is ignored.
    start_burst(16'h2000, 16'd5);
    repeat (2) @(posedge aclk);
    #1;
    start_addr  = 16'h3000;
    count_limit = 16'd9;
    start       = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    wait_done("busy5", 5);
    repeat (10) @(posedge aclk);
    #1;
    check_eq("busy5_no_extra_done", done_cnt - done_base, 1);
    check_eq("busy5_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
